// File: rtl/cpu54_div_pkg.sv
// Shared definitions for the multicycle DIV/DIVU unit.
package cpu54_div_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } div_state_e;

    function automatic logic [DIV_WIDTH-1:0] neg_if(
        input logic                 neg,
        input logic [DIV_WIDTH-1:0] v
    );
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Most negative value maps onto itself and is read as unsigned
    function automatic logic [DIV_WIDTH-1:0] abs_val(
        input logic [DIV_WIDTH-1:0] v
    );
        return neg_if(v[DIV_WIDTH-1], v);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU.
// Quotient drives LO, remainder drives HI.
module seq_divider
    import cpu54_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start,
    input  logic             divu_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             done_q, done_d;

    logic             sgn;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        dz_d    = dz_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
        sgn     = div_start;
        // quo_q shifts the dividend out as quotient bits shift in
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};

        unique case (state_q)
            S_IDLE: begin
                if (div_start || divu_start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = sgn ? abs_val(dividend) : dividend;
                    dvs_d   = sgn ? abs_val(divisor) : divisor;
                    dvd_d   = dividend;
                    qsign_d = sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rsign_d = sgn & dividend[WIDTH-1];
                    dz_d    = (divisor == '0);
                end
            end
            S_RUN: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                if (dz_q) begin
                    q_d = '1;
                    r_d = dvd_q;
                end else begin
                    q_d = neg_if(qsign_q, quo_q);
                    r_d = neg_if(rsign_q, rem_q[WIDTH-1:0]);
                end
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            dz_q    <= dz_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, signs, div-by-zero,
// ignored starts and mid-operation reset.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start;
    logic        divu_start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] q_prev = 32'h0;
    logic [31:0] r_prev = 32'h0;

    always #5 clk = ~clk;

    seq_divider dut (
        .clk       (clk),
        .rst       (rst),
        .div_start (div_start),
        .divu_start(divu_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .q         (q),
        .r         (r),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one start, optionally pulse div_start again at busy cycle inj,
    // then check busy length, done pulse and results.
    task automatic run_op(input string tag, input logic s, input logic u,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input int inj);
        int cnt;
        div_start  = s;
        divu_start = u;
        dividend   = a;
        divisor    = b;
        @(negedge clk);
        div_start  = 1'b0;
        divu_start = 1'b0;
        chk({tag, "_hold_q"}, q, q_prev);
        chk({tag, "_hold_r"}, r, r_prev);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            if (cnt == inj) begin
                div_start = 1'b1;
                dividend  = 32'h0000_0005;
                divisor   = 32'h0000_0001;
            end else begin
                div_start = 1'b0;
            end
            chk({tag, "_nodone"}, {31'b0, done}, 32'd0);
            @(negedge clk);
        end
        div_start = 1'b0;
        chk({tag, "_busy_len"}, cnt, 32'd33);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_q"}, q, eq);
        chk({tag, "_r"}, r, er);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        q_prev = eq;
        r_prev = er;
    endtask

    initial begin
        rst        = 1'b0;
        div_start  = 1'b0;
        divu_start = 1'b0;
        dividend   = 32'h0;
        divisor    = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_q", q, 32'h0);
        chk("rst_r", r, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        run_op("u100_7", 1'b0, 1'b1, 32'd100, 32'd7,
               32'h0000_000E, 32'h0000_0002, 0);
        run_op("sm7_2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002,
               32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_op("s7_m2", 1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFE,
               32'hFFFF_FFFD, 32'h0000_0001, 0);
        run_op("s_ovf", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 32'h0000_0000, 0);
        run_op("u_max", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001,
               32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op("s_dz", 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000,
               32'hFFFF_FFFF, 32'h1234_5678, 0);
        run_op("u_dz", 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000,
               32'hFFFF_FFFF, 32'h1234_5678, 0);
        run_op("ign", 1'b0, 1'b1, 32'd1000, 32'd10,
               32'h0000_0064, 32'h0000_0000, 10);
        run_op("both", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002,
               32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);

        // Reset in the middle of an operation
        div_start = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd3;
        @(negedge clk);
        div_start = 1'b0;
        repeat (14) @(negedge clk);
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_done", {31'b0, done}, 32'd0);
        chk("mrst_q", q, 32'h0);
        chk("mrst_r", r, 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("mrst_nodone", {30'b0, busy, done}, 32'd0);
        end
        q_prev = 32'h0;
        r_prev = 32'h0;
        run_op("after_rst", 1'b1, 1'b0, 32'd50, 32'd3,
               32'h0000_0010, 32'h0000_0002, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multicycle radix-2 restoring divider serving DIV and DIVU in the 54-instruction multicycle CPU.
- Sits directly downstream of the controller.
  - Consumes the controller's one-cycle div_start / divu_start pulses.
  - Returns busy, which holds the controller in its final state.
- Quotient feeds LO; remainder feeds HI, selected by the hi/lo input muxes.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk edge).
- div_start  in  1  one-cycle pulse: start signed divide.
- divu_start  in  1  one-cycle pulse: start unsigned divide.
- dividend  in  WIDTH  Rs value, sampled with start.
- divisor  in  WIDTH  Rt value, sampled with start.
- q  out  WIDTH  quotient (to LO).
- r  out  WIDTH  remainder (to HI).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse, results valid.

Behaviour:
- Reset (rst==0 at edge): state IDLE, busy=0, done=0, q=0, r=0, counter=0; in-flight operation discarded, no done pulse.
- States:
  - IDLE -> RUN on an accepted start.
  - RUN for WIDTH cycles -> FIX.
  - FIX for 1 cycle -> IDLE with done=1.
- Start acceptance:
  - Only sampled in IDLE.
  - Starts while busy=1 are ignored; the operation continues unaffected.
  - div_start and divu_start both high: signed wins.
- Latency:
  - Start sampled at edge N; busy=1 from edge N through edge N+WIDTH+1, i.e. busy high for WIDTH+1=33 cycles.
  - done=1 and busy=0 in the same cycle after FIX.
  - The controller reaches its busy check 1 cycle after start and sees busy=1.
- Capture at start:
  - Signed: store |dividend|, |divisor|, qsign = dividend[MSB] ^ divisor[MSB], rsign = dividend[MSB].
  - Unsigned: raw operands, signs = 0.
  - abs(0x80000000) = 0x80000000, treated as an unsigned magnitude.
- RUN step each cycle:
  - Partial remainder (WIDTH+1 bits) shifted left with the next dividend bit.
  - Trial subtract of divisor magnitude; if non-negative, keep the difference and set the quotient bit to 1, else restore and set 0.
  - Counter counts 0..WIDTH-1 and does not wrap beyond.
- FIX: q = qsign ? -Q : Q; r = rsign ? -R : R, both in WIDTH-bit two's complement.
- Divide by zero (captured divisor == 0), both modes: q=all-ones, r=dividend as sampled; the sign fix is bypassed. Same 33-cycle timing.
- Overflow (signed 0x80000000 / 0xFFFFFFFF): q=0x80000000, r=0, via natural wrap.
- Output hold: q/r hold their last values until the next FIX (or reset); they are not cleared at a new start.
- done is never asserted outside the cycle following FIX.

Decomposition:
- Shared package cpu54_div_pkg:
  - State enum/localparams IDLE/RUN/FIX (binary 2-bit).
  - DIV_LATENCY = WIDTH+1.
  - Default WIDTH.
- Single module; no sub-module. The abs/negate helper is a package function, not a separate instance.

Test Plan:
- Unsigned 100/7 via divu_start -> busy high exactly 33 cycles; then done pulse, q=0x0000000E, r=0x00000002.
- Signed 0xFFFFFFF9 (-7) / 0x00000002 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Also 7/-2 -> q=0xFFFFFFFD, r=0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. Unsigned 0xFFFFFFFF/0x00000001 -> q=0xFFFFFFFF, r=0.
- Divide by zero, signed and unsigned, dividend 0x12345678 -> q=0xFFFFFFFF, r=0x12345678, 33-cycle busy.
- Start pulse at cycle 10 of a running op with different operands -> ignored; original results delivered at cycle 33; simultaneous div_start+divu_start in IDLE -> signed result.
- rst=0 at cycle 15 of an op -> next cycle busy=0, q=r=0, no done; a new start after release completes normally.
